wave_seq_ctrl: RTL
==================

# wave_seq_ctrl

Parametrised successor to the waveform start-address selector in the drive-waveform path. It holds a start address and a length per waveform in a CPU-writable register file. Request pulses are latched as pending, so none are lost while the player is busy. Pending requests are granted by fixed priority, and each grant is issued to the waveform player with a start/done handshake. It sits between the request sources (power-on/off, up/down, shake, print, fill) and the waveform ROM player.

## Interface
- NUM_WAVES, 11, number of waveform channels (1..16)
- DATA_W, 8, width of start address, length and config data
- CFG_AW, 5, config address width; bit 0 = field select, bits [CFG_AW-1:1] = wave index; 2^(CFG_AW-1) >= NUM_WAVES
- RST_STRIDE, 4, reset start address of wave i = i*RST_STRIDE (truncated to DATA_W)
- RST_LEN, 3, reset length of every wave

- clk  in  1  clock
- rstn  in  1  reset rstn, asynchronous, active-low; clock clk
- req  in  NUM_WAVES  request pulses; bit i requests wave i
- cancel  in  1  flush all pending requests and abandon the current wave
- cfg_addr  in  CFG_AW  config register address
- cfg_wren  in  1  config write strobe
- cfg_data  in  DATA_W  config write data
- player_done  in  1  one-cycle pulse from the player when the current wave is finished
- wave_start  out  1  one-cycle issue pulse to the player
- wave_start_addr  out  DATA_W  start address of the issued wave
- wave_len  out  DATA_W  length of the issued wave
- wave_id  out  4  index of the issued wave
- busy  out  1  high while state != IDLE
- req_overrun  out  1  one-cycle pulse when a request hits an already-pending wave

## Operation
- Register file: per wave i, start[i] (field 0) and len[i] (field 1).
  - Write when cfg_wren = 1: wave index = cfg_addr[CFG_AW-1:1], field = cfg_addr[0].
  - Writes to an index >= NUM_WAVES are ignored.
  - Reset values: start[i] = i*RST_STRIDE, len[i] = RST_LEN.
- Pending vector, NUM_WAVES bits, reset 0:
  - Bit i is set by req[i].
  - Bit i is cleared when wave i is selected.
  - Set wins over clear in the same cycle: the new request stays pending.
- req_overrun pulses when req[i] = 1 while pending[i] = 1 and bit i is not being cleared that cycle. The request merges into the existing pending bit and is not counted twice.
- FSM states: IDLE, ISSUE, WAIT.
  - IDLE, pending != 0: select the lowest set index k and clear pending[k].
    - If len[k] != 0: latch wave_start_addr = start[k], wave_len = len[k], wave_id = k, then go to ISSUE.
    - If len[k] == 0: the wave is skipped. No pulse, outputs unchanged, stay in IDLE.
  - ISSUE: wave_start = 1 for exactly this cycle, then go to WAIT.
  - WAIT: on player_done, go to IDLE.
  - player_done in IDLE or ISSUE is ignored.
- cancel has highest priority:
  - Clears pending and forces IDLE on the next edge.
  - No wave_start is issued in that cycle, and req in the same cycle is discarded.
  - wave_start_addr, wave_len and wave_id hold their values.
- Latched outputs are stable from ISSUE through WAIT. Config writes to the active wave take effect on its next issue only.

## Timing
- Reset values: wave_start 0, wave_start_addr 0, wave_len 0, wave_id 0, busy 0, req_overrun 0, state IDLE.
- Request latency: req high at edge N sets pending after N. Selection happens at edge N+1. wave_start is high between edges N+1 and N+2, with address, length and id already valid.
- Re-issue: player_done at edge M gives IDLE after M. The next pending wave's wave_start is high between M+1 and M+2. The minimum gap between starts is 3 cycles.
- req_overrun is registered and pulses the cycle after the offending req.
- Reset asserted mid-wave: all state returns to reset values immediately; pending requests are lost.

## Test plan
- After reset, pulse req[0] -> wave_start two cycles later with addr 0x00, len 3, id 0; busy stays high until player_done.
- Write start[4] = 0x10, then pulse req[4] and req[2] together -> wave 2 issues first (addr 0x08). After player_done, wave 4 issues (addr 0x10).
- req[5] pulsed twice while wave 1 is in WAIT -> one req_overrun pulse; wave 5 issues exactly once after done.
- Write len[3] = 0, then pulse req[3] and req[6] -> wave 3 is skipped with no pulse; wave 6 issues (addr 0x18).
- During WAIT with pending = 0x0C, assert cancel -> IDLE, pending 0, no further wave_start; later player_done is ignored.
- Config write to index 12 with NUM_WAVES = 11 -> no register changes. Write to start[1] during wave 1's WAIT -> wave_start_addr unchanged until the next issue of wave 1.

Source files
------------

// File: rtl/wave_seq_ctrl.sv
// Waveform sequencer: per-wave start/length registers, pending request latch,
// fixed-priority grant and start/done handshake toward the waveform player.
module wave_seq_ctrl #(
    parameter int NUM_WAVES  = 11,
    parameter int DATA_W     = 8,
    parameter int CFG_AW     = 5,
    parameter int RST_STRIDE = 4,
    parameter int RST_LEN    = 3
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [NUM_WAVES-1:0] req,
    input  logic                 cancel,
    input  logic [CFG_AW-1:0]    cfg_addr,
    input  logic                 cfg_wren,
    input  logic [DATA_W-1:0]    cfg_data,
    input  logic                 player_done,
    output logic                 wave_start,
    output logic [DATA_W-1:0]    wave_start_addr,
    output logic [DATA_W-1:0]    wave_len,
    output logic [3:0]           wave_id,
    output logic                 busy,
    output logic                 req_overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_W-1:0]     start_q [NUM_WAVES];
    logic [DATA_W-1:0]     len_q   [NUM_WAVES];
    logic [NUM_WAVES-1:0]  pending_q, pending_d;
    logic [DATA_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wlen_q, wlen_d;
    logic [3:0]            id_q, id_d;
    logic                  ovr_q, ovr_d;

    logic [CFG_AW-2:0]     cfg_idx;
    logic [3:0]            sel_idx;
    logic                  sel_hit;
    logic                  sel_valid;
    logic [NUM_WAVES-1:0]  clr_vec;
    logic [NUM_WAVES-1:0]  one_vec;

    assign cfg_idx = cfg_addr[CFG_AW-1:1];
    assign one_vec = NUM_WAVES'(1);

    // Index values >= NUM_WAVES match no entry, so such writes fall away.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NUM_WAVES; i++) begin
                start_q[i] <= DATA_W'(i * RST_STRIDE);
                len_q[i]   <= DATA_W'(RST_LEN);
            end
        end else if (cfg_wren) begin
            for (int i = 0; i < NUM_WAVES; i++) begin
                if (cfg_idx == (CFG_AW-1)'(i)) begin
                    if (cfg_addr[0]) len_q[i] <= cfg_data;
                    else             start_q[i] <= cfg_data;
                end
            end
        end
    end

    // Lowest set index wins.
    always_comb begin
        sel_idx = '0;
        sel_hit = 1'b0;
        for (int i = NUM_WAVES - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                sel_idx = 4'(i);
                sel_hit = 1'b1;
            end
        end
    end

    assign sel_valid = (state_q == IDLE) && sel_hit && !cancel;
    assign clr_vec   = sel_valid ? (one_vec << sel_idx) : '0;

    // A request arriving with its own clear keeps the bit set.
    always_comb begin
        pending_d = '0;
        ovr_d     = 1'b0;
        if (!cancel) begin
            pending_d = (pending_q & ~clr_vec) | req;
            ovr_d     = |(req & pending_q & ~clr_vec);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wlen_d  = wlen_q;
        id_d    = id_q;
        unique case (state_q)
            IDLE: begin
                if (sel_valid && (len_q[sel_idx] != '0)) begin
                    state_d = ISSUE;
                    addr_d  = start_q[sel_idx];
                    wlen_d  = len_q[sel_idx];
                    id_d    = sel_idx;
                end
            end
            ISSUE: state_d = WAIT;
            WAIT: if (player_done) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (cancel) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            wlen_q    <= '0;
            id_q      <= '0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            addr_q    <= addr_d;
            wlen_q    <= wlen_d;
            id_q      <= id_d;
            ovr_q     <= ovr_d;
        end
    end

    assign wave_start      = (state_q == ISSUE) && !cancel;
    assign wave_start_addr = addr_q;
    assign wave_len        = wlen_q;
    assign wave_id         = id_q;
    assign busy            = (state_q != IDLE);
    assign req_overrun     = ovr_q;

endmodule
